// File: rtl/anti_theft_ctrl.sv
// Vehicle anti-theft controller: door-triggered alarm with a 1 Hz countdown,
// run-time programmable delays, blinking ARMED LED and a fuel-pump interlock.
module anti_theft_ctrl #(
  parameter int NUM_DOORS   = 4,
  parameter int CNT_W       = 4,
  parameter int T_ARM_DEF   = 6,
  parameter int T_DRV_DEF   = 8,
  parameter int T_PASS_DEF  = 15,
  parameter int T_ALARM_DEF = 10,
  parameter int BLINK_DIV   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_tick_1hz,
  input  logic                 i_ignition,
  input  logic [NUM_DOORS-1:0] i_doors,
  input  logic                 i_hidden_sw,
  input  logic                 i_brake,
  input  logic                 i_reprogram,
  input  logic [1:0]           i_prog_sel,
  input  logic [CNT_W-1:0]     i_prog_val,
  output logic                 o_status,
  output logic                 o_siren,
  output logic                 o_fuel_pump,
  output logic [2:0]           o_state,
  output logic [CNT_W-1:0]     o_timer
);

  typedef enum logic [2:0] {
    S_ARMED      = 3'd0,
    S_TRIGGERED  = 3'd1,
    S_ALARM      = 3'd2,
    S_DISARMED   = 3'd3,
    S_WAIT_OPEN  = 3'd4,
    S_WAIT_CLOSE = 3'd5,
    S_WAIT_ARM   = 3'd6,
    S_ILLEGAL    = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] L_ARM_DEF   = CNT_W'(T_ARM_DEF);
  localparam logic [CNT_W-1:0] L_DRV_DEF   = CNT_W'(T_DRV_DEF);
  localparam logic [CNT_W-1:0] L_PASS_DEF  = CNT_W'(T_PASS_DEF);
  localparam logic [CNT_W-1:0] L_ALARM_DEF = CNT_W'(T_ALARM_DEF);
  localparam logic [CNT_W-1:0] L_ONE       = CNT_W'(1);

  localparam int               BLINK_W      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] L_BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_timer;
  logic [CNT_W-1:0]     w_timer_nxt;
  logic [CNT_W-1:0]     r_t_arm;
  logic [CNT_W-1:0]     r_t_drv;
  logic [CNT_W-1:0]     r_t_pass;
  logic [CNT_W-1:0]     r_t_alarm;
  logic [BLINK_W-1:0]   r_blink_cnt;
  logic                 r_blink_phase;
  logic                 r_status;
  logic                 r_siren;
  logic                 r_pump;
  logic                 w_status_nxt;
  logic                 w_siren_nxt;
  logic                 w_pump_nxt;

  logic                 w_any_door;
  logic                 w_drv_only;
  logic                 w_expire;
  logic [CNT_W-1:0]     w_count;

  assign w_any_door = |i_doors;
  assign w_drv_only = (i_doors == NUM_DOORS'(1));
  // A loaded 0 or 1 expires at the very first tick.
  assign w_expire   = i_tick_1hz && (r_timer <= L_ONE);
  // Running count: only reached when not expiring, so a tick never wraps below 1.
  assign w_count    = i_tick_1hz ? (r_timer - L_ONE) : r_timer;

  // State register and countdown timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ARMED;
      r_timer <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Next-state and timer-load logic; reprogram overrides every state rule.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    w_state_nxt = r_state;
    w_timer_nxt = '0;
    if (i_reprogram) begin
      w_state_nxt = S_ARMED;
    end else begin
      unique case (r_state)
        S_ARMED: begin
          if (w_any_door) begin
            w_state_nxt = S_TRIGGERED;
            w_timer_nxt = w_drv_only ? r_t_drv : r_t_pass;
          end else if (i_ignition) begin
            w_state_nxt = S_DISARMED;
          end
        end
        S_TRIGGERED: begin
          if (w_expire) begin
            w_state_nxt = S_ALARM;
            w_timer_nxt = r_t_alarm;
          end else if (i_ignition) begin
            w_state_nxt = S_DISARMED;
          end else begin
            w_timer_nxt = w_count;
          end
        end
        S_ALARM: begin
          // An open door keeps the siren hold time topped up.
          if (w_any_door) begin
            w_timer_nxt = r_t_alarm;
          end else if (w_expire) begin
            w_state_nxt = S_ARMED;
          end else begin
            w_timer_nxt = w_count;
          end
        end
        S_DISARMED: begin
          if (!i_ignition) w_state_nxt = S_WAIT_OPEN;
        end
        S_WAIT_OPEN: begin
          if (i_doors[0])      w_state_nxt = S_WAIT_CLOSE;
          else if (i_ignition) w_state_nxt = S_DISARMED;
        end
        S_WAIT_CLOSE: begin
          if (!i_doors[0]) begin
            w_state_nxt = S_WAIT_ARM;
            w_timer_nxt = r_t_arm;
          end else if (i_ignition) begin
            w_state_nxt = S_DISARMED;
          end
        end
        S_WAIT_ARM: begin
          if (i_ignition) begin
            w_state_nxt = S_DISARMED;
          end else if (i_doors[0]) begin
            w_state_nxt = S_WAIT_CLOSE;
          end else if (w_expire) begin
            w_state_nxt = S_ARMED;
          end else begin
            w_timer_nxt = w_count;
          end
        end
        default: w_state_nxt = S_ARMED;
      endcase
    end
  end

  // Programmable delays; writing 0 restores the built-in default.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t_arm   <= L_ARM_DEF;
      r_t_drv   <= L_DRV_DEF;
      r_t_pass  <= L_PASS_DEF;
      r_t_alarm <= L_ALARM_DEF;
    end else if (i_reprogram) begin
      unique case (i_prog_sel)
        2'd0: r_t_arm   <= (i_prog_val == '0) ? L_ARM_DEF   : i_prog_val;
        2'd1: r_t_drv   <= (i_prog_val == '0) ? L_DRV_DEF   : i_prog_val;
        2'd2: r_t_pass  <= (i_prog_val == '0) ? L_PASS_DEF  : i_prog_val;
        default: r_t_alarm <= (i_prog_val == '0) ? L_ALARM_DEF : i_prog_val;
      endcase
    end
  end

  // ARMED blink generator: counts ticks while ARMED, toggles every BLINK_DIV ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (i_reprogram || (r_state != S_ARMED)) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (i_tick_1hz) begin
      if (r_blink_cnt == L_BLINK_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end
    end
  end

  // Output decode from the current state, registered below.
  always_comb begin
    w_status_nxt = 1'b0;
    w_siren_nxt  = (r_state == S_ALARM);
    w_pump_nxt   = r_pump;
    unique case (r_state)
      S_ARMED:              w_status_nxt = r_blink_phase;
      S_TRIGGERED, S_ALARM: w_status_nxt = 1'b1;
      default:              w_status_nxt = 1'b0;
    endcase
    // Pump latches on in DISARMED and survives leaving it until the key is off.
    if (!i_ignition) begin
      w_pump_nxt = 1'b0;
    end else if ((r_state == S_DISARMED) && i_hidden_sw && i_brake) begin
      w_pump_nxt = 1'b1;
    end
  end

  // Registered driver outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= 1'b0;
      r_siren  <= 1'b0;
      r_pump   <= 1'b0;
    end else begin
      r_status <= w_status_nxt;
      r_siren  <= w_siren_nxt;
      r_pump   <= w_pump_nxt;
    end
  end

  assign o_status    = r_status;
  assign o_siren     = r_siren;
  assign o_fuel_pump = r_pump;
  assign o_state     = r_state;
  assign o_timer     = r_timer;

endmodule

// File: tb/tb_anti_theft_ctrl.sv
// Bench for anti_theft_ctrl: directed scenarios plus randomized traffic, each
// clock edge predicted by a behavioural model and checked by a scoreboard monitor.
module tb_anti_theft_ctrl;

  localparam int NUM_DOORS = 4;
  localparam int CNT_W     = 4;
  localparam int BLINK_DIV = 2;

  localparam int M_ARMED = 0, M_TRIG = 1, M_ALARM = 2, M_DIS = 3;
  localparam int M_WOPEN = 4, M_WCLOSE = 5, M_WARM = 6;

  logic                 clk;
  logic                 rst_n;
  logic                 tick;
  logic                 ign;
  logic [NUM_DOORS-1:0] doors;
  logic                 hid;
  logic                 brk;
  logic                 rep;
  logic [1:0]           sel;
  logic [CNT_W-1:0]     val;
  logic                 o_status;
  logic                 o_siren;
  logic                 o_fuel_pump;
  logic [2:0]           o_state;
  logic [CNT_W-1:0]     o_timer;

  anti_theft_ctrl #(
    .NUM_DOORS(NUM_DOORS), .CNT_W(CNT_W), .T_ARM_DEF(6), .T_DRV_DEF(8),
    .T_PASS_DEF(15), .T_ALARM_DEF(10), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_tick_1hz(tick), .i_ignition(ign), .i_doors(doors),
    .i_hidden_sw(hid), .i_brake(brk), .i_reprogram(rep), .i_prog_sel(sel),
    .i_prog_val(val), .o_status(o_status), .o_siren(o_siren), .o_fuel_pump(o_fuel_pump),
    .o_state(o_state), .o_timer(o_timer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int state;
    int timer;
    int status;
    int siren;
    int pump;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Behavioural model state
  int m_mode, m_timer, m_armed_ticks, m_status, m_siren, m_pump;
  int m_dly[4];

  function automatic int def_delay(input int s);
    case (s)
      0: return 6;
      1: return 8;
      2: return 15;
      default: return 10;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Advance the model across one clock edge using the inputs held for that edge.
  task automatic model_step();
    int  phase, nt;
    int  n_status, n_siren, n_pump;
    bit  expire;
    if (!rst_n) begin
      m_mode = M_ARMED; m_timer = 0; m_armed_ticks = 0;
      m_status = 0; m_siren = 0; m_pump = 0;
      for (int i = 0; i < 4; i++) m_dly[i] = def_delay(i);
      return;
    end
    phase    = (m_armed_ticks / BLINK_DIV) % 2;
    n_status = (m_mode == M_ARMED) ? phase : ((m_mode == M_TRIG || m_mode == M_ALARM) ? 1 : 0);
    n_siren  = (m_mode == M_ALARM) ? 1 : 0;
    if (!ign)                                 n_pump = 0;
    else if (m_mode == M_DIS && hid && brk)   n_pump = 1;
    else                                      n_pump = m_pump;
    if (rep || m_mode != M_ARMED) m_armed_ticks = 0;
    else if (tick)                m_armed_ticks++;

    expire = tick && (m_timer <= 1);
    nt     = tick ? m_timer - 1 : m_timer;
    if (rep) begin
      m_mode = M_ARMED; m_timer = 0;
      m_dly[sel] = (val == 0) ? def_delay(int'(sel)) : int'(val);
    end else begin
      case (m_mode)
        M_ARMED:
          if (doors != 0) begin
            m_mode = M_TRIG; m_timer = (doors == 4'b0001) ? m_dly[1] : m_dly[2];
          end else if (ign) m_mode = M_DIS;
        M_TRIG:
          if (expire)   begin m_mode = M_ALARM; m_timer = m_dly[3]; end
          else if (ign) begin m_mode = M_DIS;   m_timer = 0; end
          else m_timer = nt;
        M_ALARM:
          if (doors != 0)  m_timer = m_dly[3];
          else if (expire) begin m_mode = M_ARMED; m_timer = 0; end
          else m_timer = nt;
        M_DIS:
          if (!ign) m_mode = M_WOPEN;
        M_WOPEN:
          if (doors[0]) m_mode = M_WCLOSE;
          else if (ign) m_mode = M_DIS;
        M_WCLOSE:
          if (!doors[0]) begin m_mode = M_WARM; m_timer = m_dly[0]; end
          else if (ign)  m_mode = M_DIS;
        M_WARM:
          if (ign)           begin m_mode = M_DIS;    m_timer = 0; end
          else if (doors[0]) begin m_mode = M_WCLOSE; m_timer = 0; end
          else if (expire)   begin m_mode = M_ARMED;  m_timer = 0; end
          else m_timer = nt;
        default: begin m_mode = M_ARMED; m_timer = 0; end
      endcase
    end
    m_status = n_status; m_siren = n_siren; m_pump = n_pump;
  endtask

  // One clock: predict the edge, queue the expectation, return at negedge+1.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    model_step();
    e.state = m_mode; e.timer = m_timer; e.status = m_status;
    e.siren = m_siren; e.pump = m_pump;
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    tick = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Each second: two quiet cycles then one tick cycle.
  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b0; step(); step();
      tick = 1'b1; step();
    end
    tick = 1'b0;
  endtask

  // Scoreboard monitor: samples DUT outputs on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("state",  int'(o_state),     e.state);
        check("timer",  int'(o_timer),     e.timer);
        check("status", int'(o_status),    e.status);
        check("siren",  int'(o_siren),     e.siren);
        check("pump",   int'(o_fuel_pump), e.pump);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0; tick = 1'b0; ign = 1'b0; doors = '0; hid = 1'b0; brk = 1'b0;
    rep = 1'b0; sel = 2'd0; val = '0;
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Blink in ARMED
    run_ticks(6);

    // Driver door -> TRIGGERED with driver delay, then ALARM
    doors = 4'b0001; step();
    check("t2_state", int'(o_state), 1);
    check("t2_timer", int'(o_timer), 8);
    doors = 4'b0000;
    run_ticks(8);
    idle(1);
    check("t2_alarm_state", int'(o_state), 2);
    check("t2_alarm_timer", int'(o_timer), 10);
    check("t2_siren", int'(o_siren), 1);
    run_ticks(3);

    // Reset pulse mid-ALARM
    rst_n = 1'b0; step();
    check("rst_state", int'(o_state), 0);
    check("rst_siren", int'(o_siren), 0);
    rst_n = 1'b1; idle(2);

    // Passenger door held open through ALARM
    doors = 4'b0100; step();
    check("t3_timer", int'(o_timer), 15);
    run_ticks(15);
    run_ticks(20);
    check("t3_siren_held", int'(o_siren), 1);
    doors = 4'b0000;
    run_ticks(10);
    idle(2);
    check("t3_back_armed", int'(o_state), 0);
    check("t3_siren_off", int'(o_siren), 0);

    // Drive cycle with pump interlock and re-arm
    ign = 1'b1; idle(2);
    hid = 1'b1; brk = 1'b1; idle(2);
    check("t4_pump_on", int'(o_fuel_pump), 1);
    hid = 1'b0; brk = 1'b0; idle(2);
    ign = 1'b0; idle(2);
    check("t4_pump_off", int'(o_fuel_pump), 0);
    doors = 4'b0001; idle(1);
    doors = 4'b0000; idle(1);
    run_ticks(3);
    doors = 4'b0001; idle(1);
    doors = 4'b0000; idle(1);
    run_ticks(6);
    idle(2);
    check("t4_rearmed", int'(o_state), 0);

    // Reprogram beats a simultaneous door
    rep = 1'b1; sel = 2'd1; val = 4'd3; doors = 4'b0001; step();
    check("t5_rep_state", int'(o_state), 0);
    rep = 1'b0; doors = 4'b0000; idle(1);
    doors = 4'b0001; step();
    check("t5_timer3", int'(o_timer), 3);
    doors = 4'b0000;
    run_ticks(4);
    run_ticks(11);
    idle(2);
    rep = 1'b1; sel = 2'd1; val = 4'd0; idle(1); rep = 1'b0;

    // Delay of 1 expires at the first tick
    rep = 1'b1; sel = 2'd1; val = 4'd1; idle(1); rep = 1'b0;
    doors = 4'b0001; idle(1); doors = 4'b0000;
    run_ticks(1);
    run_ticks(11);
    rep = 1'b1; sel = 2'd1; val = 4'd0; idle(1); rep = 1'b0;

    // Ignition while TRIGGERED at timer=2
    doors = 4'b0001; idle(1); doors = 4'b0000;
    run_ticks(6);
    ign = 1'b1; idle(2);
    check("t6_disarmed", int'(o_state), 3);
    ign = 1'b0; idle(2);
    doors = 4'b0001; idle(1); doors = 4'b0000; idle(1);
    run_ticks(7);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 29) == 0) ign = ~ign;
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 4))
          0, 1:    doors = '0;
          2:       doors = 4'b0001;
          default: doors = NUM_DOORS'($urandom_range(0, 15));
        endcase
      end
      hid = ($urandom_range(0, 1) == 1);
      brk = ($urandom_range(0, 1) == 1);
      rep = ($urandom_range(0, 59) == 0);
      sel = 2'($urandom_range(0, 3));
      val = CNT_W'($urandom_range(0, 4));
      step();
    end
    rep = 1'b0; tick = 1'b0;
    idle(3);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    check("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
